// File: rtl/mem_responder.sv
// Memory-side responder for the Enable/RW/MFC four-phase handshake.
// Latches the request, waits WAIT_CYCLES states, accesses the array, then holds MFC until Enable drops.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Enable,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              MFC,
    output logic              Busy,
    output logic              Abort
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic              rw_r;
    logic [DATA_W-1:0] data_r;
    logic              latch_s;
    logic              access_s;
    logic              abort_s;

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Next-state, wait counter and access strobes
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        latch_s      = 1'b0;
        access_s     = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Enable) begin
                    latch_s      = 1'b1;
                    cnt_next_s   = 4'd0;
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A drop on the completion edge still counts as an abort
                if (!Enable) begin
                    abort_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (cnt_r == WAIT_LIM) begin
                    access_s     = 1'b1;
                    state_next_s = ST_ACK;
                end else begin
                    cnt_next_s   = cnt_r + 4'd1;
                end
            end
            ST_ACK: begin
                if (!Enable) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State, request latch and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            rw_r    <= 1'b0;
            data_r  <= '0;
            DataOut <= '0;
            MFC     <= 1'b0;
            Busy    <= 1'b0;
            Abort   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            MFC     <= (state_next_s == ST_ACK);
            Busy    <= (state_next_s != ST_IDLE);
            Abort   <= abort_s;
            if (latch_s) begin
                addr_r <= Addr;
                rw_r   <= RW;
                data_r <= DataIn;
            end
            if (access_s && rw_r) begin
                DataOut <= mem_r[addr_r];
            end
        end
    end

    // Storage array: never cleared, written only on a completed store
    always_ff @(posedge clk) begin
        if (reset && access_s && !rw_r) begin
            mem_r[addr_r] <= data_r;
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the Enable/RW/MFC handshake driven by the load/store control FSM. It latches address, direction and write data when Enable is sampled high, then inserts a parameterised number of wait states. It then performs the access on an internal register array and asserts MFC (memory function complete) until the initiator drops Enable. It sits between the MAR/MDR datapath and storage, and replaces an ideal zero-latency memory model in the microcontroller.

## Interface
- ADDR_W, 8, address width; array depth is 2^ADDR_W words
- DATA_W, 16, data word width
- WAIT_CYCLES, 2, wait states inserted before completion; legal range 0..15

- clk  input  1  system clock; all state changes on posedge clk only
- reset  input  1  synchronous, active-low reset, sampled on posedge clk
- Enable  input  1  access request from initiator; level-held for the whole transaction
- RW  input  1  direction: 1 = read (load), 0 = write (store); sampled with Enable
- Addr  input  ADDR_W  word address (MAR contents); sampled with Enable
- DataIn  input  DATA_W  write data (MDR contents); sampled with Enable
- DataOut  output  DATA_W  read data toward MDR; registered
- MFC  output  1  memory function complete; registered, Moore from ACK state
- Busy  output  1  high whenever state != IDLE
- Abort  output  1  one-cycle pulse when a transaction is cancelled by Enable falling before MFC

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: if Enable=1, latch Addr, RW and DataIn into internal registers, clear the wait counter, and go to WAIT. Otherwise stay in IDLE.
- WAIT, Enable=0: go to IDLE and pulse Abort. No array write occurs and DataOut is unchanged.
- WAIT, Enable=1, counter == WAIT_CYCLES: perform the access and go to ACK.
  - Write: array[latched addr] <= latched data.
  - Read: DataOut <= array[latched addr].
- WAIT, Enable=1, counter < WAIT_CYCLES: increment the counter (4-bit).
- ACK: MFC=1. Stay while Enable=1; go to IDLE when Enable=0 is sampled.
- Four-phase handshake: leaving ACK requires Enable low, so a held-high Enable never starts a second access.
- Addr, RW and DataIn may change after the latch edge without effect. Only latched values are used.
- DataOut holds the last read value. Writes and idle cycles do not change it.
- Array contents are not cleared by reset and are undefined at power-up. Benches write before reading.

## Timing
- Reset (reset=0 at posedge): state=IDLE, counter=0, MFC=0, Busy=0, Abort=0, DataOut=0. Any in-flight access is dropped with no array write.
- Edge E0 samples Enable=1 in IDLE. The access completes on edge E(WAIT_CYCLES+1), and MFC is high in the cycle after that edge.
  - WAIT_CYCLES=0: MFC high after E1.
  - WAIT_CYCLES=2: MFC high after E3.
- DataOut is valid in the same cycle MFC first goes high and stays stable through ACK.
- MFC falls in the cycle after the edge that samples Enable=0 in ACK. The next request can be latched on the following edge at the earliest.
- Busy rises the cycle after E0 and falls together with MFC (or with Abort).
- Abort is high for exactly one cycle, following the edge that samples Enable=0 in WAIT.
- Simultaneous events:
  - reset=0 wins over everything.
  - An Enable drop on the completion edge (counter == WAIT_CYCLES, Enable=0) is an abort, with no write.

## Test plan
- Write, WAIT_CYCLES=2: Enable=1, RW=0, Addr=0x12, DataIn=0xBEEF -> MFC rises 3 cycles after the latch edge and Busy=1 throughout. Drop Enable -> MFC=0 next cycle. Later read of 0x12 returns 0xBEEF.
- Read, WAIT_CYCLES=2: after the write above, Enable=1, RW=1, Addr=0x12; change Addr to 0x34 one cycle later -> DataOut=0xBEEF with MFC, using the latched address. Hold Enable 5 extra cycles -> MFC stays 1, no second access, DataOut stable.
- Abort: start a write of 0x1234 to 0x05 (prior contents 0x0000) and drop Enable during WAIT -> Abort pulses 1 cycle, MFC never rises, Busy=0. Read of 0x05 returns 0x0000.
- Reset mid-transaction: assert reset=0 during WAIT of a write of 0xAAAA to 0x07 -> MFC=0, Busy=0, DataOut=0 after the edge. Reading 0x07 shows its pre-write value.
- WAIT_CYCLES=0: write 0x5A5A to 0xFF, then read it back -> MFC high 1 cycle after each latch edge and DataOut=0x5A5A. Back-to-back transactions are separated by the minimum one-cycle Enable-low gap.
